// File: rtl/spi_slave_if_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_slave_if_pkg : FSM encoding and status bit indices for spi_slave_if
// Revision 1.0
// ---------------------------------------------------------------------------
package spi_slave_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

  localparam int unsigned STATUS_W = 3;
  localparam int unsigned ST_OVR   = 0;
  localparam int unsigned ST_UND   = 1;
  localparam int unsigned ST_FRM   = 2;

  // Sticky update: a set event wins over a simultaneous clear.
  function automatic logic [STATUS_W-1:0] status_next(input logic [STATUS_W-1:0] cur,
                                                      input logic                clr,
                                                      input logic [STATUS_W-1:0] set);
    return (clr ? '0 : cur) | set;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_slave_fifo : synchronous RX FIFO, combinational head read
// Revision 1.0
// ---------------------------------------------------------------------------
module spi_slave_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned     PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned     CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_slave_if : SPI mode-0 target, RX FIFO + one-word TX hold. Optional irq
// output with `define SPI_SLAVE_IRQ_EN.                         Revision 1.0
// ---------------------------------------------------------------------------
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int unsigned      DATA_W     = 8,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_TX   = DATA_W'(8'hFF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SPI_SCK,
  input  logic                SPI_MOSI,
  input  logic                SPI_nSS,
  output logic                SPI_MISO,
  output logic                SPI_MISO_OE,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                tx_wr,
  output logic                tx_ready,
  output logic [DATA_W-1:0]   rx_data,
  output logic                rx_valid,
  input  logic                rx_rd,
  output logic                busy,
  output logic [STATUS_W-1:0] status,
  input  logic                status_clr
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int unsigned      BC_W     = $clog2(DATA_W);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);

  logic [2:0]          sck_sync_q, nss_sync_q;
  logic [1:0]          mosi_sync_q;
  logic                sck_rise, sck_fall, nss_fall, nss_s, mosi_s;

  spi_state_e          state_q, state_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   hold_q;
  logic                hold_full_q, hold_full_d;
  logic [STATUS_W-1:0] status_q, status_set;
  logic                push, reload, frm_set, tx_accept;
  logic                fifo_full, fifo_empty;

  // Bit 1 of each synchroniser is the settled value, bit 2 its previous sample.
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign nss_s    = nss_sync_q[1];
  assign nss_fall = ~nss_sync_q[1] & nss_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];

  assign tx_accept = tx_wr & ~hold_full_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    push       = 1'b0;
    reload     = 1'b0;
    frm_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (nss_fall) state_d = LOAD;
      end
      LOAD: begin
        reload    = 1'b1;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (nss_s) begin
          frm_set   = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            push      = 1'b1;
            reload    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall && bit_cnt_q != '0) begin
          // The fall after a word's last rise already shows the reloaded MSB.
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
    if (reload) tx_shift_d = hold_full_q ? hold_q : IDLE_TX;

    hold_full_d = hold_full_q;
    if (tx_accept)   hold_full_d = 1'b1;
    else if (reload) hold_full_d = 1'b0;

    status_set         = '0;
    status_set[ST_OVR] = push & fifo_full & ~rx_rd;
    status_set[ST_UND] = reload & ~hold_full_q;
    status_set[ST_FRM] = frm_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      nss_sync_q  <= '0;
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      status_q    <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], SPI_SCK};
      nss_sync_q  <= {nss_sync_q[1:0], SPI_nSS};
      mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_full_q <= hold_full_d;
      if (tx_accept) hold_q <= tx_data;
      status_q    <= status_next(status_q, status_clr, status_set);
    end
  end

  spi_slave_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (rx_shift_d),
    .pop_i   (rx_rd),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign SPI_MISO    = (state_q != IDLE) ? tx_shift_q[DATA_W-1] : 1'b0;
  assign SPI_MISO_OE = (state_q != IDLE) & ~nss_s;
  assign tx_ready    = ~hold_full_q;
  assign rx_valid    = ~fifo_empty;
  assign busy        = (state_q == SHIFT);
  assign status      = status_q;

`ifdef SPI_SLAVE_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= rx_valid | (|status_q);
  end
  assign irq = irq_q;
`else
  // No interrupt line: software polls rx_valid and status.
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_slave_if : directed + random SPI master bench with reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SPI_SCK = 1'b0, SPI_MOSI = 1'b0, SPI_nSS = 1'b1;
  logic       SPI_MISO, SPI_MISO_OE;
  logic [7:0] tx_data = '0;
  logic       tx_wr = 1'b0, rx_rd = 1'b0, status_clr = 1'b0;
  logic       tx_ready, rx_valid, busy;
  logic [7:0] rx_data;
  logic [2:0] status;
`ifdef SPI_SLAVE_IRQ_EN
  logic       irq;
`endif

  spi_slave_if dut (
    .clk(clk), .rst(rst),
    .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI), .SPI_nSS(SPI_nSS),
    .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd),
    .busy(busy), .status(status), .status_clr(status_clr)
`ifdef SPI_SLAVE_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: transmit hold, RX queue of depth 4, sticky {frm, und, ovr}
  logic [7:0] rxq[$];
  logic [7:0] hold_m;
  bit         hold_full_m;
  logic [2:0] st_m;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    rxq.delete();
    hold_full_m = 1'b0;
    hold_m      = '0;
    st_m        = '0;
  endtask

  task automatic consume(output logic [7:0] w);
    if (hold_full_m) begin
      w = hold_m;
      hold_full_m = 1'b0;
    end else begin
      w = 8'hFF;
      st_m[1] = 1'b1;
    end
  endtask

  task automatic push_m(input logic [7:0] w);
    if (rxq.size() == 4) st_m[0] = 1'b1;
    else rxq.push_back(w);
  endtask

  task automatic wr_tx(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    tick(1);
    tx_wr   = 1'b0;
    if (!hold_full_m) begin
      hold_m = d;
      hold_full_m = 1'b1;
    end
  endtask

  task automatic clr_status();
    status_clr = 1'b1;
    tick(1);
    status_clr = 1'b0;
    st_m = '0;
  endtask

  task automatic pop_chk(input string tag);
    chk({tag, "_rx_valid"}, rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) chk({tag, "_rx_data"}, rx_data, rxq[0]);
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
    if (rxq.size() != 0) void'(rxq.pop_front());
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_status"}, status, st_m);
    chk({tag, "_rx_valid"}, rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) chk({tag, "_rx_data"}, rx_data, rxq[0]);
    chk({tag, "_tx_ready"}, tx_ready, !hold_full_m);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_miso_oe"}, SPI_MISO_OE, 1'b0);
`ifdef SPI_SLAVE_IRQ_EN
    chk({tag, "_irq"}, irq, (rxq.size() != 0) || (st_m != 0));
`endif
  endtask

  // Mode 0, SCK = clk/8: MOSI set while SCK low, MISO sampled just before the rise.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit pop_last,
                      output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = mo[7-i];
      tick(4);
      mi[7-i] = SPI_MISO;
      SPI_SCK = 1'b1;
      if (pop_last && i == 7) begin
        tick(2);
        rx_rd = 1'b1;
        tick(1);
        rx_rd = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      SPI_SCK = 1'b0;
    end
    tick(4);
  endtask

  task automatic frame(input string tag, input logic [7:0] mo[$], input bit refill,
                       input bit pop_last);
    logic [7:0] exp_w, mi;
    if (refill && !hold_full_m) wr_tx(8'($urandom));
    SPI_nSS = 1'b0;
    tick(6);
    chk({tag, "_busy_in"}, busy, 1'b1);
    chk({tag, "_oe_in"}, SPI_MISO_OE, 1'b1);
    consume(exp_w);
    if (refill) wr_tx(8'($urandom));
    foreach (mo[k]) begin
      xfer(mo[k], 8, pop_last && (k == mo.size() - 1), mi);
      chk({tag, "_miso"}, mi, exp_w);
      if (pop_last && k == mo.size() - 1 && rxq.size() != 0) void'(rxq.pop_front());
      push_m(mo[k]);
      consume(exp_w);
      if (refill && k != mo.size() - 1) wr_tx(8'($urandom));
    end
    SPI_nSS = 1'b1;
    tick(6);
    check_all(tag);
  endtask

  task automatic partial(input string tag, input logic [7:0] mo, input int nbits);
    logic [7:0] exp_w, mi;
    if (!hold_full_m) wr_tx(8'($urandom));
    SPI_nSS = 1'b0;
    tick(6);
    consume(exp_w);
    xfer(mo, nbits, 1'b0, mi);
    chk({tag, "_miso"}, mi >> (8 - nbits), exp_w >> (8 - nbits));
    SPI_nSS = 1'b1;
    tick(6);
    if (nbits != 0) st_m[2] = 1'b1;
    check_all(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] mi;
    model_reset();

    // Reset state
    tick(3);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_status", status, 3'b000);
    chk("rst_miso", SPI_MISO, 1'b0);
    chk("rst_miso_oe", SPI_MISO_OE, 1'b0);
    rst = 1'b0;
    tick(2);

    // 1: hold 0xA5, master sends 0x3C; a second write while full is ignored
    wr_tx(8'hA5);
    wr_tx(8'h5A);
    chk("t1_tx_ready", tx_ready, 1'b0);
    q = '{8'h3C};
    frame("t1", q, 1'b1, 1'b0);
    chk("t1_rx_data", rx_data, 8'h3C);
    pop_chk("t1_pop");

    // 2: hold empty -> master reads 0xFF, underrun
    q = '{8'h55};
    frame("t2", q, 1'b0, 1'b0);
    chk("t2_status", status, 3'b010);
    chk("t2_rx_data", rx_data, 8'h55);
    pop_chk("t2_pop");
    clr_status();
    chk("t2_clr", status, 3'b000);

    // 3: five words with no reads -> first four kept, overrun
    q = '{};
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    frame("t3", q, 1'b1, 1'b0);
    chk("t3_status", status, 3'b001);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", rx_data, q[i]);
      pop_chk("t3_pop");
    end
    chk("t3_empty", rx_valid, 1'b0);
    clr_status();

    // 4: nSS released after 5 rises -> frame error, FIFO unchanged
    q = '{8'($urandom)};
    frame("t4a", q, 1'b1, 1'b0);
    partial("t4", 8'($urandom), 5);
    chk("t4_status", status, 3'b100);
    pop_chk("t4_pop");
    clr_status();

    // 5: full FIFO, pop coincident with next push -> no overrun, order kept
    q = '{};
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    frame("t5a", q, 1'b1, 1'b0);
    q = '{8'($urandom)};
    frame("t5b", q, 1'b1, 1'b1);
    chk("t5_status", status, 3'b000);
    for (int i = 0; i < 4; i++) pop_chk("t5_pop");
    chk("t5_empty", rx_valid, 1'b0);

    // 6: reset after 3 bits, then a clean 0x81 frame
    wr_tx(8'($urandom));
    SPI_nSS = 1'b0;
    tick(6);
    xfer(8'($urandom), 3, 1'b0, mi);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    tick(8);
    chk("t6_busy_after_rst", busy, 1'b0);
    check_all("t6_rst");
    SPI_nSS = 1'b1;
    tick(6);
    q = '{8'h81};
    frame("t6", q, 1'b1, 1'b0);
    chk("t6_rx_data", rx_data, 8'h81);
    chk("t6_status", status, 3'b000);
    pop_chk("t6_pop");
    chk("t6_empty", rx_valid, 1'b0);

    // Random frames against the model
    for (int n = 0; n < 8; n++) begin
      q = '{};
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) q.push_back(8'($urandom));
      frame("rnd", q, ($urandom % 4) != 0, ($urandom % 3) == 0);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) pop_chk("rnd_pop");
      if (($urandom % 3) == 0) clr_status();
      check_all("rnd_idle");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
